inst_fetch: RTL
===============

# inst_fetch

Instruction fetch stage that owns the program counter, drives the word address of the instruction ROM and buffers fetched words in a 2-entry queue toward the decode stage. It accepts PC redirects from branch/jump resolution and presents instruction/PC pairs to decode over a valid/ready handshake. It stops fetching at the end of ROM space.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ROM_WORDS`, default 1024: instruction ROM depth in words; fetches at word index >= ROM_WORDS are not issued.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `imem_addr` output 32: byte address to the instruction ROM; equals `pc`; the ROM returns its word combinationally in the same cycle.
- `imem_rdata` input 32: instruction word from the ROM.
- `redirect_valid` input 1: load a new PC this cycle.
- `redirect_pc` input 32: target byte address.
- `out_valid` output 1: buffer head is valid.
- `out_ready` input 1: decode accepts the head this cycle.
- `out_instr` output 32: head instruction.
- `out_pc` output 32: byte address of the head instruction.
- `out_pc4` output 32: `out_pc + 4`, modulo 2^32.
- `halted` output 1: state is END.
- `fault` output 1: misaligned redirect was seen (only with the macro).

## Operation
- State register: RUN, END, FAULT. Reset value is RUN.
- Buffer: 2 entries of {instr, pc}, with a 2-bit count (0..2). Head is the oldest entry. `out_valid` = (count != 0).
- pop = out_valid & out_ready.
- can_push = state==RUN & (pc[31:2] < ROM_WORDS) & (count<2 | pop).
- Priority on each edge:
  1. Redirect: count <= 0. Any pop that cycle is still counted as consumed. pc <= redirect_pc. No push. State becomes RUN, or FAULT (see Configuration).
  2. Otherwise, if can_push: push {imem_rdata, pc} and set pc <= pc + 4, modulo 2^32.
  3. Otherwise, if state==RUN and pc[31:2] >= ROM_WORDS: state <= END. pc holds. Entries already buffered still drain.
  4. Otherwise: pc holds. This is the full case, with count==2 and no pop.
- END: no fetch. Only a redirect leaves END.
- FAULT: no fetch, and redirects are ignored. Exit is by reset only.
- Push and pop in the same cycle: count is unchanged and order is preserved. This holds at count==2.
- Reset mid-operation clears everything asynchronously.

## Timing
- Reset values:
  - pc = RESET_PC, count = 0, state = RUN.
  - out_valid = 0, out_instr = 0, out_pc = 0, out_pc4 = 4.
  - halted = 0, fault = 0.
  - imem_addr = RESET_PC.
- First instruction: out_valid = 1 after the first rising edge with rst_n high. out_instr = ROM[RESET_PC>>2].
- Throughput: 1 instruction per cycle while out_ready = 1.
- Redirect sampled at edge N: out_valid = 0 during cycle N+1. The target instruction is the head after edge N+1.
- A stalled head (out_ready = 0) holds out_instr and out_pc stable.
- The buffer fills to 2, then pc freezes.
- `out_*` are driven from the buffer head registers. There is no combinational path from imem_rdata to out_*.
- `halted` and `fault` are registered. They assert in the cycle after the edge that entered END or FAULT.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - A redirect with redirect_pc[1:0] != 0 flushes the buffer, enters FAULT and sets `fault` = 1. `fault` is sticky until reset.
  - pc is loaded with the unmodified target.
- `IFETCH_ALIGN_CHECK_EN` undefined:
  - pc loads {redirect_pc[31:2], 2'b00}.
  - FAULT is unreachable and `fault` is tied to 0.

## Test plan
- Reset release with ROM[0..3] = 0x20080001, 0x20090002, 0x01095020, 0x00000000, and out_ready = 1: out_pc sequence is 0, 4, 8, 12 on consecutive cycles, with matching out_instr and out_pc4 = out_pc + 4.
- out_ready = 0 for 5 cycles after reset: count reaches 2 and imem_addr holds at 0x8. out_instr stays 0x20080001. Raising out_ready then yields pc 0, 4, 8 with no gap.
- Redirect to 0x40 while count = 2 and out_ready = 1: out_valid = 0 for one cycle, then out_pc = 0x40, 0x44.
- Redirect to 0xFFC with ROM_WORDS = 1024: one instruction at 0xFFC, then halted = 1 and out_valid falls. A later redirect to 0x0 clears halted and fetches 0x0.
- Macro on, redirect to 0x42: fault = 1 and out_valid = 0. A redirect to 0x0 is ignored. Asserting rst_n = 0 clears fault.
- Macro off, redirect to 0x42: out_pc = 0x40 and fault stays 0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and
// buffers fetched {instr, pc} pairs in a 2-entry queue toward decode.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects
// into a sticky FAULT state; otherwise redirect targets are word-aligned.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {RUN, END, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_instr_q, head_instr_d, head_pc_q, head_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d, tail_pc_q, tail_pc_d;

  logic        pop, can_push, in_rom, redirect_take, misalign;
  logic [31:0] target;
  logic [1:0]  slot;

  assign in_rom        = ({2'b00, pc_q[31:2]} < ROM_WORDS);
  assign pop           = (count_q != 2'd0) && out_ready;
  assign can_push      = (state_q == RUN) && in_rom && ((count_q != 2'd2) || pop);
  assign redirect_take = redirect_valid && (state_q != FAULT);
  // Entry position a new word lands in once the popped head has left.
  assign slot          = count_q - {1'b0, pop};

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target   = redirect_pc;
  assign misalign = (redirect_pc[1:0] != 2'b00);
  assign fault    = (state_q == FAULT);
`else
  assign target   = redirect_pc & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
  assign fault    = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;
  assign out_pc4   = head_pc_q + 32'd4;
  assign halted    = (state_q == END);

  // Next-state: redirect beats push, push beats end-of-ROM detection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    if (redirect_take) begin
      count_d = 2'd0;
      pc_d    = target;
      state_d = misalign ? FAULT : RUN;
    end else begin
      // A pop shifts the tail forward; a same-cycle push may overwrite it below.
      if (pop) begin
        head_instr_d = tail_instr_q;
        head_pc_d    = tail_pc_q;
      end
      if (can_push) begin
        if (slot == 2'd0) begin
          head_instr_d = imem_rdata;
          head_pc_d    = pc_q;
        end else begin
          tail_instr_d = imem_rdata;
          tail_pc_d    = pc_q;
        end
        count_d = slot + 2'd1;
        pc_d    = pc_q + 32'd4;
      end else begin
        count_d = slot;
        if ((state_q == RUN) && !in_rom) state_d = END;
      end
    end
  end

  // State, PC and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      count_q      <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

endmodule
